// File: rtl/div16u8_seq_pkg.sv
// Shared types and constants for the sequential 16/8 unsigned divider.
// The package name is div_pkg so future divider variants can share it.
package div_pkg;

  localparam int W_Q = 8;
  localparam int W_D = 2 * W_Q;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic [W_Q-1:0] Q_SAT = '1;

endpackage

// File: rtl/div16u8_seq_if.sv
// Operand and result handshake bundle for div16u8_seq.
// master = producer/consumer side, slave = divider side.
interface div16u8_seq_if;
  import div_pkg::*;

  // Both channels use strict valid/ready: a transfer happens on a rising edge
  // where valid & ready are both high; a raised valid holds its data stable.
  logic           in_valid;
  logic           in_ready;
  logic [W_D-1:0] dividend;
  logic [W_Q-1:0] divisor;
  logic           out_valid;
  logic           out_ready;
  logic [W_Q-1:0] quotient;
  logic [W_Q-1:0] remainder;
  logic           ovf;
  logic           dbz;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, ovf, dbz
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, ovf, dbz
  );

endinterface

// File: rtl/div16u8_seq_step.sv
// One radix-2 restoring division iteration; purely combinational so that
// approximate step variants can replace it without touching the control.
module div_restoring_step
  import div_pkg::*;
#(
  parameter int WQ = W_Q
) (
  input  logic [WQ:0]   r,
  input  logic [WQ-1:0] q,
  input  logic [WQ-1:0] divisor,
  output logic [WQ:0]   r_next,
  output logic [WQ-1:0] q_next
);

  logic [WQ:0] t;
  logic        ge;

  // r[WQ] is shifted out of t; if it were ever set the true partial
  // remainder would exceed any divisor, so it forces a subtract.
  always_comb begin
    t      = {r[WQ-1:0], q[WQ-1]};
    ge     = r[WQ] | (t >= {1'b0, divisor});
    r_next = ge ? (t - {1'b0, divisor}) : t;
    q_next = {q[WQ-2:0], ge};
  end

endmodule

// File: rtl/div16u8_seq.sv
// Sequential unsigned 16-by-8 restoring divider, one quotient bit per clock,
// with saturating results for divide-by-zero and quotient overflow.
module div16u8_seq
  import div_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  div16u8_seq_if.slave       bus,
  output div_state_t         state_dbg
);

  div_state_t     state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [W_Q:0]   r_q, r_d;
  logic [W_Q-1:0] q_q, q_d;
  logic [W_Q-1:0] dvs_q, dvs_d;
  logic [W_Q-1:0] quo_q, quo_d;
  logic [W_Q-1:0] rem_q, rem_d;
  logic           ovf_q, ovf_d;
  logic           dbz_q, dbz_d;
  logic           out_valid_q, out_valid_d;

  logic [W_Q:0]   r_next;
  logic [W_Q-1:0] q_next;

  div_restoring_step #(.WQ(W_Q)) u_step (
    .r       (r_q),
    .q       (q_q),
    .divisor (dvs_q),
    .r_next  (r_next),
    .q_next  (q_next)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    r_d         = r_q;
    q_d         = q_q;
    dvs_d       = dvs_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    ovf_d       = ovf_q;
    dbz_d       = dbz_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.divisor == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            dbz_d       = 1'b1;
            ovf_d       = 1'b0;
            quo_d       = Q_SAT;
            rem_d       = bus.dividend[W_Q-1:0];
          end else if (bus.dividend[W_D-1:W_Q] >= bus.divisor) begin
            // Quotient would need more than W_Q bits.
            state_d     = DONE;
            out_valid_d = 1'b1;
            dbz_d       = 1'b0;
            ovf_d       = 1'b1;
            quo_d       = Q_SAT;
            rem_d       = '0;
          end else begin
            state_d = CALC;
            r_d     = {1'b0, bus.dividend[W_D-1:W_Q]};
            q_d     = bus.dividend[W_Q-1:0];
            dvs_d   = bus.divisor;
            cnt_d   = '0;
          end
        end
      end
      CALC: begin
        r_d   = r_next;
        q_d   = q_next;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          quo_d       = q_next;
          rem_d       = r_next[W_Q-1:0];
          ovf_d       = 1'b0;
          dbz_d       = 1'b0;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      q_q         <= q_d;
      dvs_q       <= dvs_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE) & ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.ovf       = ovf_q;
  assign bus.dbz       = dbz_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_div16u8_seq.sv
// Directed and small randomized checks of div16u8_seq with a result scoreboard.
module tb_div16u8_seq;
  import div_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  div_state_t state_dbg;

  div16u8_seq_if bus();

  div16u8_seq dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [17:0] exp_q[$];  // {ovf, dbz, quotient, remainder}

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_result(input string tag);
    logic [17:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, {14'd0, bus.ovf, bus.dbz, bus.quotient, bus.remainder}, {14'd0, e});
    end
  endtask

  // ---------------- driver tasks ----------------
  // Returns 1 ns after the acceptance edge.
  task automatic send(input logic [15:0] a, input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_eq("accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Counts rising edges from acceptance until out_valid, bounded.
  task automatic wait_out(output int cyc);
    cyc = 1;
    while (!bus.out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                        input logic [17:0] e, input int exp_lat);
    int cyc;
    exp_q.push_back(e);
    send(a, b);
    wait_out(cyc);
    check_eq({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    check_result(tag);
    consume();
    check_eq({tag, "_drop"}, {31'd0, bus.out_valid}, 32'd0);
    check_eq({tag, "_rdy"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int seen;
    logic [15:0] held_q;
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  hi;

    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check_eq("rst_outputs", {13'd0, bus.out_valid, bus.ovf, bus.dbz, bus.quotient, bus.remainder}, 32'd0);
    check_eq("rst_state", {30'd0, state_dbg}, {30'd0, IDLE});
    rst = 1'b0;
    #1;
    check_eq("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // 1000 / 7 with in_ready low throughout CALC.
    exp_q.push_back({2'b00, 8'd142, 8'd6});
    send(16'd1000, 8'd7);
    check_eq("calc_state", {30'd0, state_dbg}, {30'd0, CALC});
    seen = 0;
    cyc  = 1;
    while (!bus.out_valid && cyc < 40) begin
      if (bus.in_ready) seen++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("calc_in_ready", 32'(seen), 32'd0);
    check_eq("d1000_lat", 32'(cyc), 32'd9);
    check_result("d1000");
    consume();

    run_op("d65024", 16'd65024, 8'd255, {2'b00, 8'd254, 8'd254}, 9);
    run_op("d0_1",   16'd0,     8'd1,   {2'b00, 8'd0,   8'd0},   9);
    run_op("dbz",    16'd1234,  8'd0,   {2'b01, 8'hFF,  8'hD2},  1);
    run_op("ovf",    16'h1200,  8'h12,  {2'b10, 8'hFF,  8'h00},  1);

    // Backpressure: 50000 / 200 held 5 cycles while inputs churn.
    exp_q.push_back({2'b00, 8'd250, 8'd0});
    send(16'd50000, 8'd200);
    wait_out(cyc);
    check_eq("hold_lat", 32'(cyc), 32'd9);
    held_q = {bus.quotient, bus.remainder};
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = ~bus.in_valid;
      bus.dividend = 16'($urandom_range(0, 65535));
      bus.divisor  = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      if ({bus.quotient, bus.remainder} !== held_q || !bus.out_valid || bus.in_ready) seen++;
    end
    check_eq("hold_stable", 32'(seen), 32'd0);
    check_result("hold");
    @(negedge clk);
    bus.in_valid = 1'b0;
    consume();
    check_eq("hold_rdy", {31'd0, bus.in_ready}, 32'd1);
    exp_q.push_back({2'b00, 8'd15, 8'd0});
    send(16'd45, 8'd3);
    check_eq("hold_next_acc", {30'd0, state_dbg}, {30'd0, CALC});
    wait_out(cyc);
    check_result("hold_next");
    consume();

    // Reset during CALC after step 4 discards the operation.
    send(16'd1000, 8'd7);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_state", {30'd0, state_dbg}, {30'd0, IDLE});
    check_eq("mid_rst_ov", {31'd0, bus.out_valid}, 32'd0);
    check_eq("mid_rst_rdy", {31'd0, bus.in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("mid_rel_rdy", {31'd0, bus.in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check_eq("mid_no_result", 32'(seen), 32'd0);
    run_op("d300_9", 16'd300, 8'd9, {2'b00, 8'd33, 8'd3}, 9);

    // Random in-range operands with random consumer stalls.
    for (int k = 0; k < 150; k++) begin
      b  = 8'($urandom_range(1, 255));
      hi = 8'($urandom_range(0, int'(b) - 1));
      a  = {hi, 8'($urandom_range(0, 255))};
      exp_q.push_back({2'b00, 8'(a / b), 8'(a % b)});
      send(a, b);
      wait_out(cyc);
      check_eq("rand_lat", 32'(cyc), 32'd9);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      check_result("rand");
      consume();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
